mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 tb/tb_mul_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding its 64-bit result in HI/LO.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division.
// Both work on operand magnitudes, and the sign is fixed up in the last state.
//
// state | meaning
// IDLE  | waiting for start; done/div_by_zero show the last result for one cycle
// CALC  | WIDTH iterations of shift-add or restoring divide
// FIX   | sign correction, HI/LO write, done pulse registered
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;

   logic               sa_in;
   logic               sb_in;
   logic [WIDTH-1:0]   mag_a_in;
   logic [WIDTH-1:0]   mag_b_in;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   a_orig;
   logic               b_zero;

   // Operand magnitudes at start.
   // Negating 0x80..0 gives itself, which is the correct unsigned magnitude.
   always_comb begin
      sa_in    = op[0] & operand_a[WIDTH-1];
      sb_in    = op[0] & operand_b[WIDTH-1];
      mag_a_in = sa_in ? -operand_a : operand_a;
      mag_b_in = sb_in ? -operand_b : operand_b;
   end

   // One iteration step.
   // Multiply keeps {partial product, remaining multiplier bits} in acc.
   // Divide keeps {partial remainder, dividend bits / quotient bits} in acc.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      if (!is_div)
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
         acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   // Sign fixup.
   // The remainder follows the dividend's sign, so the quotient truncates toward zero.
   // The raw dividend is rebuilt from its magnitude for the divide-by-zero case.
   always_comb begin
      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      a_orig   = sign_a ? -mag_a : mag_a;
      b_zero   = (mag_b == {WIDTH{1'b0}});
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         cnt         <= '0;
         is_div      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         mag_a       <= '0;
         mag_b       <= '0;
         acc         <= '0;
      end else begin
         case (state)
            IDLE: begin
               done        <= 1'b0;
               div_by_zero <= 1'b0;
               if (start) begin
                  state  <= CALC;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  is_div <= op[1];
                  sign_a <= sa_in;
                  sign_b <= sb_in;
                  mag_a  <= mag_a_in;
                  mag_b  <= mag_b_in;
                  acc    <= op[1] ? {{WIDTH{1'b0}}, mag_a_in} : {{WIDTH{1'b0}}, mag_b_in};
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               if (!is_div) begin
                  hi          <= prod_fix[2*WIDTH-1:WIDTH];
                  lo          <= prod_fix[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end else if (b_zero) begin
                  hi          <= a_orig;
                  lo          <= {WIDTH{1'b1}};
                  div_by_zero <= 1'b1;
               end else begin
                  hi          <= rem_fix;
                  lo          <= quo_fix;
                  div_by_zero <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a
// reference model, and handshake/reset corner sequences.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[10];

   mul_div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      longint      sx;
      longint      sy;
      logic [63:0] p;
      logic [63:0] q;
      logic [63:0] r;
      e.dbz = 1'b0;
      sx = o[0] ? longint'($signed(x)) : longint'({32'b0, x});
      sy = o[0] ? longint'($signed(y)) : longint'({32'b0, y});
      if (!o[1]) begin
         p = sx * sy;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (y == 32'd0) begin
         e.hi = x;
         e.lo = 32'hFFFF_FFFF;
         e.dbz = 1'b1;
      end else begin
         q = sx / sy;
         r = sx % sy;
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      return e;
   endfunction

   // Drive a start request at the current negedge and record the expected result.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
      start     = 1'b1;
      op        = o;
      operand_a = x;
      operand_b = y;
      sb.push_back(e);
   endtask

   // Wait for done (bounded), then compare latency, busy length, hold behaviour and result.
   task automatic run_and_check(input string tag, input int glitch_at, input bit check_after);
      int          edges;
      int          bcnt;
      bit          hold_ok;
      logic [31:0] h0;
      logic [31:0] l0;
      exp_t        e;
      h0 = hi;
      l0 = lo;
      @(negedge clk);
      start   = 1'b0;
      edges   = 1;
      bcnt    = 0;
      hold_ok = 1'b1;
      while (!done && edges < 100) begin
         if (busy) bcnt++;
         if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
         if (edges == glitch_at) begin
            start     = 1'b1;
            op        = 2'b01;
            operand_a = 32'h5;
            operand_b = 32'h1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      start = 1'b0;
      chk({tag, " done_seen"}, done, 1);
      chk({tag, " latency"}, edges, 34);
      chk({tag, " busy_cycles"}, bcnt, 33);
      chk({tag, " hilo_hold"}, hold_ok, 1);
      chk({tag, " busy_in_done"}, busy, 0);
      chk({tag, " sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, " hi"}, hi, e.hi);
         chk({tag, " lo"}, lo, e.lo);
         chk({tag, " div_by_zero"}, div_by_zero, e.dbz);
      end
      if (check_after) begin
         @(negedge clk);
         chk({tag, " done_after"}, done, 0);
         chk({tag, " dbz_after"}, div_by_zero, 0);
      end
   endtask

   initial begin
      bit          saw_done;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[4] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[6] = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      vecs[7] = '{2'b01, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
      vecs[8] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
      vecs[9] = '{2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};

      reset = 1'b1;
      start = 1'b0;
      op = 2'b00;
      operand_a = '0;
      operand_b = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset dbz", div_by_zero, 0);
      chk("reset hi", hi, 0);
      chk("reset lo", lo, 0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, '{vecs[i].hi, vecs[i].lo, vecs[i].dbz});
         run_and_check($sformatf("vec%0d", i), 0, 1'b1);
      end

      for (int i = 0; i < 6; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         issue(ro, ra, rb, ref_model(ro, ra, rb));
         run_and_check($sformatf("rnd%0d", i), 0, 1'b1);
      end

      // start pulsed mid-operation with different operands must be ignored
      issue(2'b10, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0});
      run_and_check("ignore_start", 10, 1'b1);

      // start in the done cycle is accepted
      issue(2'b01, 32'hFFFF_FFFD, 32'd5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
      run_and_check("b2b_first", 0, 1'b0);
      issue(2'b00, 32'h0000_FFFF, 32'h0000_FFFF, '{32'h0, 32'hFFFE_0001, 1'b0});
      run_and_check("b2b_second", 0, 1'b1);

      // reset at edge 15 of a DIVU aborts it
      start = 1'b1;
      op = 2'b10;
      operand_a = 32'h1000;
      operand_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort hi", hi, 0);
      chk("abort lo", lo, 0);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("abort no_done", saw_done, 0);
      issue(2'b00, 32'd4, 32'd4, '{32'd0, 32'd16, 1'b0});
      run_and_check("after_abort", 0, 1'b1);

      chk("sb drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
